// File: rtl/cache_controller.sv
// Control FSM for a write-back, write-allocate cache in front of a fixed-latency memory.
// Ports: cpu_read/cpu_write/hit/dirty_bit in; stall, cache/memory strobes and hit/miss counters out.
module cache_controller #(
  parameter int unsigned MEM_LATENCY = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             cpu_read,
  input  logic             cpu_write,
  input  logic             hit,
  input  logic             dirty_bit,
  output logic             stall,
  output logic             cache_we,
  output logic             cache_src,
  output logic             mem_in_select,
  output logic             mem_we,
  output logic             mem_re,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int unsigned CW = $clog2(MEM_LATENCY + 1);
  localparam logic [CW-1:0] LAST = CW'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WB,
    ALLOC
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] hit_q, hit_d;
  logic [CNT_W-1:0] miss_q, miss_d;

  logic req;
  logic store;

  // A simultaneous read and write is treated as a store.
  assign req   = cpu_read | cpu_write;
  assign store = cpu_write;

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    hit_d         = hit_q;
    miss_d        = miss_q;
    stall         = 1'b0;
    cache_we      = 1'b0;
    cache_src     = 1'b0;
    mem_in_select = 1'b0;
    mem_we        = 1'b0;
    mem_re        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            cache_we  = store;
            cache_src = store;
            hit_d     = hit_q + CNT_W'(1);
          end else begin
            stall   = 1'b1;
            miss_d  = miss_q + CNT_W'(1);
            cnt_d   = '0;
            state_d = dirty_bit ? WB : ALLOC;
          end
        end
      end
      WB: begin
        stall         = 1'b1;
        mem_in_select = 1'b1;
        mem_we        = 1'b1;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = ALLOC;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ALLOC: begin
        stall  = 1'b1;
        mem_re = 1'b1;
        if (cnt_q == LAST) begin
          // Fill write: memory data, clears the dirty bit.
          cache_we = 1'b1;
          cnt_d    = '0;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    // Outputs are held quiet for the whole reset cycle.
    if (rst_b) begin
      stall         = 1'b0;
      cache_we      = 1'b0;
      cache_src     = 1'b0;
      mem_in_select = 1'b0;
      mem_we        = 1'b0;
      mem_re        = 1'b0;
    end
  end

  assign hit_count  = rst_b ? '0 : hit_q;
  assign miss_count = rst_b ? '0 : miss_q;

endmodule

// File: tb/tb_cache_controller.sv
// Directed testbench for cache_controller (MEM_LATENCY=4, CNT_W=16).
// Drives inputs 1ns after the rising edge, samples outputs on the falling edge.
module tb_cache_controller;

  logic        clk;
  logic        rst_b;
  logic        cpu_read;
  logic        cpu_write;
  logic        hit;
  logic        dirty_bit;
  logic        stall;
  logic        cache_we;
  logic        cache_src;
  logic        mem_in_select;
  logic        mem_we;
  logic        mem_re;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  int checks;
  int failures;

  int st_n, re_n, we_n, ov_n, sel_bad, cw_n, src_bad, cw_pos;
  bit tmo;

  cache_controller #(
    .MEM_LATENCY(4),
    .CNT_W      (16)
  ) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .cpu_read     (cpu_read),
    .cpu_write    (cpu_write),
    .hit          (hit),
    .dirty_bit    (dirty_bit),
    .stall        (stall),
    .cache_we     (cache_we),
    .cache_src    (cache_src),
    .mem_in_select(mem_in_select),
    .mem_we       (mem_we),
    .mem_re       (mem_re),
    .hit_count    (hit_count),
    .miss_count   (miss_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_b     = 1'b1;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    hit       = 1'b0;
    dirty_bit = 1'b0;
    step();
    step();
    rst_b = 1'b0;
  endtask

  // Walks a miss from the cycle after the IDLE decision until stall drops.
  // Raises hit once the fill strobe has been seen.
  task automatic run_miss(input bit drop,
                          output int o_st, output int o_re,
                          output int o_we, output int o_ov,
                          output int o_sel, output int o_cw,
                          output int o_src, output int o_pos,
                          output bit o_tmo);
    bit fill;
    fill  = 1'b0;
    o_st  = 0;
    o_re  = 0;
    o_we  = 0;
    o_ov  = 0;
    o_sel = 0;
    o_cw  = 0;
    o_src = 0;
    o_pos = 0;
    o_tmo = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (drop) begin
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
      end
      if (fill) hit = 1'b1;
      smp();
      if (!stall) begin
        o_tmo = 1'b0;
        break;
      end
      o_st++;
      if (mem_re) o_re++;
      if (mem_we) o_we++;
      if (mem_re && mem_we) o_ov++;
      if (mem_we && !mem_in_select) o_sel++;
      if (mem_re && mem_in_select) o_sel++;
      if (cache_we) begin
        o_cw++;
        if (cache_src) o_src++;
        o_pos = o_re;
        fill  = 1'b1;
      end
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    clk       = 1'b0;
    // Reset with an active dirty-miss request: outputs must stay 0.
    rst_b     = 1'b1;
    cpu_read  = 1'b1;
    cpu_write = 1'b1;
    hit       = 1'b0;
    dirty_bit = 1'b1;
    smp();
    chk("rst_stall", stall, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_sel", mem_in_select, 0);
    step();
    smp();
    chk("rst_hits", hit_count, 0);
    chk("rst_miss", miss_count, 0);

    // Load hit.
    step();
    rst_b     = 1'b0;
    cpu_read  = 1'b1;
    cpu_write = 1'b0;
    hit       = 1'b1;
    dirty_bit = 1'b0;
    smp();
    chk("ld_hit_stall", stall, 0);
    chk("ld_hit_we", cache_we, 0);
    chk("ld_hit_re", mem_re, 0);
    step();
    cpu_read = 1'b0;
    smp();
    chk("ld_hit_cnt", hit_count, 1);
    chk("ld_hit_miss", miss_count, 0);

    // Store hit.
    step();
    cpu_write = 1'b1;
    hit       = 1'b1;
    smp();
    chk("st_hit_we", cache_we, 1);
    chk("st_hit_src", cache_src, 1);
    chk("st_hit_stall", stall, 0);
    step();
    cpu_write = 1'b0;
    smp();
    chk("st_hit_we_off", cache_we, 0);
    chk("st_hit_cnt", hit_count, 2);

    // Clean load miss.
    do_reset();
    cpu_read = 1'b1;
    smp();
    chk("cm_dec_stall", stall, 1);
    chk("cm_dec_re", mem_re, 0);
    run_miss(1'b0, st_n, re_n, we_n, ov_n, sel_bad, cw_n, src_bad,
             cw_pos, tmo);
    chk("cm_timeout", tmo, 0);
    chk("cm_stall_n", st_n, 4);
    chk("cm_re_n", re_n, 4);
    chk("cm_we_n", we_n, 0);
    chk("cm_fill_n", cw_n, 1);
    chk("cm_fill_pos", cw_pos, 4);
    chk("cm_fill_src", src_bad, 0);
    chk("cm_sel", sel_bad, 0);
    chk("cm_done_we", cache_we, 0);
    step();
    cpu_read = 1'b0;
    hit      = 1'b0;
    smp();
    chk("cm_miss_cnt", miss_count, 1);
    chk("cm_hit_cnt", hit_count, 1);

    // Dirty store miss.
    do_reset();
    cpu_write = 1'b1;
    dirty_bit = 1'b1;
    smp();
    chk("dm_dec_stall", stall, 1);
    chk("dm_dec_we", mem_we, 0);
    run_miss(1'b0, st_n, re_n, we_n, ov_n, sel_bad, cw_n, src_bad,
             cw_pos, tmo);
    chk("dm_timeout", tmo, 0);
    chk("dm_stall_n", st_n, 8);
    chk("dm_we_n", we_n, 4);
    chk("dm_re_n", re_n, 4);
    chk("dm_overlap", ov_n, 0);
    chk("dm_sel", sel_bad, 0);
    chk("dm_fill_n", cw_n, 1);
    chk("dm_fill_pos", cw_pos, 4);
    chk("dm_fill_src", src_bad, 0);
    chk("dm_done_we", cache_we, 1);
    chk("dm_done_src", cache_src, 1);
    chk("dm_done_stall", stall, 0);
    step();
    cpu_write = 1'b0;
    smp();
    chk("dm_miss_cnt", miss_count, 1);
    chk("dm_hit_cnt", hit_count, 1);

    // Reset pulsed in the second ALLOC cycle.
    do_reset();
    cpu_read = 1'b1;
    smp();
    step();
    smp();
    chk("ra_alloc1_re", mem_re, 1);
    step();
    rst_b = 1'b1;
    smp();
    chk("ra_rst_stall", stall, 0);
    chk("ra_rst_re", mem_re, 0);
    chk("ra_rst_miss", miss_count, 0);
    step();
    rst_b    = 1'b0;
    cpu_read = 1'b0;
    smp();
    chk("ra_idle_re", mem_re, 0);
    chk("ra_idle_stall", stall, 0);
    chk("ra_hits", hit_count, 0);
    chk("ra_miss", miss_count, 0);

    // Clean miss with the request dropped after the decision cycle.
    do_reset();
    cpu_read = 1'b1;
    smp();
    run_miss(1'b1, st_n, re_n, we_n, ov_n, sel_bad, cw_n, src_bad,
             cw_pos, tmo);
    chk("dr_timeout", tmo, 0);
    chk("dr_re_n", re_n, 4);
    chk("dr_fill_n", cw_n, 1);
    chk("dr_done_we", cache_we, 0);
    chk("dr_done_re", mem_re, 0);
    step();
    hit = 1'b0;
    smp();
    chk("dr_idle_re", mem_re, 0);
    chk("dr_idle_stall", stall, 0);
    chk("dr_miss_cnt", miss_count, 1);
    chk("dr_hit_cnt", hit_count, 0);

    // 2^16 consecutive load hits wrap hit_count.
    step();
    cpu_read = 1'b1;
    hit      = 1'b1;
    repeat (65535) step();
    smp();
    chk("wrap_max", hit_count, 16'hffff);
    step();
    cpu_read = 1'b0;
    smp();
    chk("wrap_zero", hit_count, 0);
    chk("wrap_miss", miss_count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
